// File: rtl/pipeline_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit_if
//
// Bundles the signals exchanged between the pipeline control/datapath and the
// hazard unit.
//   master : pipeline side. Drives the Decode register addresses and the
//            stage-qualified control status. Receives the stall, flush and
//            forward controls and the event counters.
//   slave  : hazard unit side. Directions are the mirror image of master.
//
// Signal summary:
//   RA1D, RA2D, WA3D   Decode-stage source and destination register addresses
//   RegWriteM/W        condition-qualified register writes, Memory/Writeback
//   MemtoRegE          the instruction in Execute is a load
//   BranchTakenE       branch resolved taken in Execute
//   PCW_DEM, PCSrcW    PC write pending in D/E/M, PC write commits in W
//   clrCounters        synchronous clear of both event counters
//   ForwardAE/BE       ALU operand select: 00 regfile, 01 ResultW, 10 ALUResultM
//   stallF, stallD     hold the PC / hold the Fetch-to-Decode register
//   flushD, flushE     clear the Fetch-to-Decode / Decode-to-Execute register
//   ldStallCount       saturating count of load-use stall cycles
//   branchCount        saturating count of taken-branch cycles
//
// Handshake semantics: there is no valid/ready flow control. Every input is
// sampled every cycle. Every control output is a combinational function of the
// current inputs and the hazard unit's registers, and is valid before the next
// rising clock edge.
// -----------------------------------------------------------------------------
interface pipeline_hazard_unit_if #(
    parameter int REG_BITS  = 4,
    parameter int CNT_WIDTH = 16
);
    logic [REG_BITS-1:0]  RA1D;
    logic [REG_BITS-1:0]  RA2D;
    logic [REG_BITS-1:0]  WA3D;
    logic                 RegWriteM;
    logic                 RegWriteW;
    logic                 MemtoRegE;
    logic                 BranchTakenE;
    logic                 PCW_DEM;
    logic                 PCSrcW;
    logic                 clrCounters;
    logic [1:0]           ForwardAE;
    logic [1:0]           ForwardBE;
    logic                 stallF;
    logic                 stallD;
    logic                 flushD;
    logic                 flushE;
    logic [CNT_WIDTH-1:0] ldStallCount;
    logic [CNT_WIDTH-1:0] branchCount;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
               BranchTakenE, PCW_DEM, PCSrcW, clrCounters,
        input  ForwardAE, ForwardBE, stallF, stallD, flushD, flushE,
               ldStallCount, branchCount
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
               BranchTakenE, PCW_DEM, PCSrcW, clrCounters,
        output ForwardAE, ForwardBE, stallF, stallD, flushD, flushE,
               ldStallCount, branchCount
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Hazard and forwarding controller for a five-stage ARM pipeline. It keeps its
// own copy of the register-address pipeline (Execute, Memory and Writeback) so
// it can detect dependencies. From that pipeline it produces the forwarding
// selects and the stall/flush controls. It also keeps two saturating event
// counters: load-use stall cycles and taken-branch cycles.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset. Clears the address pipeline and
//          both counters.
//   hz     pipeline_hazard_unit_if.slave. Carries the Decode addresses and the
//          control status in, and the stall/flush/forward controls and the
//          counters out.
//
// There is no FSM. The only state is the address pipeline and the counters.
// -----------------------------------------------------------------------------
module pipeline_hazard_unit #(
    parameter int REG_BITS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_unit_if.slave   hz
);

    // Address pipeline registers
    logic [REG_BITS-1:0]  ra1e_q, ra1e_d;
    logic [REG_BITS-1:0]  ra2e_q, ra2e_d;
    logic [REG_BITS-1:0]  wa3e_q, wa3e_d;
    logic [REG_BITS-1:0]  wa3m_q, wa3m_d;
    logic [REG_BITS-1:0]  wa3w_q, wa3w_d;

    // Event counters
    logic [CNT_WIDTH-1:0] ld_cnt_q, ld_cnt_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;

    logic       ldr_stall;
    logic       flush_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // Hazard detection and forwarding.
    // Memory is checked before Writeback because it holds the younger result.
    // Bubbles carry address 0, but the control unit forces their RegWrite and
    // MemtoReg low, so a match on 0 never produces a false hazard.
    always_comb begin
        ldr_stall = hz.MemtoRegE & ((hz.RA1D == wa3e_q) | (hz.RA2D == wa3e_q));

        fwd_a = 2'b00;
        if (hz.RegWriteM && (ra1e_q == wa3m_q)) begin
            fwd_a = 2'b10;
        end else if (hz.RegWriteW && (ra1e_q == wa3w_q)) begin
            fwd_a = 2'b01;
        end

        fwd_b = 2'b00;
        if (hz.RegWriteM && (ra2e_q == wa3m_q)) begin
            fwd_b = 2'b10;
        end else if (hz.RegWriteW && (ra2e_q == wa3w_q)) begin
            fwd_b = 2'b01;
        end

        flush_e = ldr_stall | hz.BranchTakenE;
    end

    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;
    assign hz.stallD    = ldr_stall;
    assign hz.stallF    = ldr_stall | hz.PCW_DEM;
    // When a load-use stall and a taken branch coincide, stallD and flushD are
    // both high. The datapath gives the flush priority at the Fetch-to-Decode
    // register.
    assign hz.flushD    = hz.PCW_DEM | hz.PCSrcW | hz.BranchTakenE;
    assign hz.flushE    = flush_e;

    assign hz.ldStallCount = ld_cnt_q;
    assign hz.branchCount  = br_cnt_q;

    // Next state. The Execute copy is zeroed on flushE, the same way the
    // datapath inserts a bubble. Memory and Writeback shift every cycle with
    // no enable, in step with the control-unit pipeline registers.
    always_comb begin
        ra1e_d = flush_e ? '0 : hz.RA1D;
        ra2e_d = flush_e ? '0 : hz.RA2D;
        wa3e_d = flush_e ? '0 : hz.WA3D;
        wa3m_d = wa3e_q;
        wa3w_d = wa3m_q;

        // clrCounters wins over increment. The counters hold at all-ones.
        ld_cnt_d = ld_cnt_q;
        if (hz.clrCounters) begin
            ld_cnt_d = '0;
        end else if (ldr_stall && (ld_cnt_q != '1)) begin
            ld_cnt_d = ld_cnt_q + 1'b1;
        end

        br_cnt_d = br_cnt_q;
        if (hz.clrCounters) begin
            br_cnt_d = '0;
        end else if (hz.BranchTakenE && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra1e_q   <= '0;
            ra2e_q   <= '0;
            wa3e_q   <= '0;
            wa3m_q   <= '0;
            wa3w_q   <= '0;
            ld_cnt_q <= '0;
            br_cnt_q <= '0;
        end else begin
            ra1e_q   <= ra1e_d;
            ra2e_q   <= ra2e_d;
            wa3e_q   <= wa3e_d;
            wa3m_q   <= wa3m_d;
            wa3w_q   <= wa3w_d;
            ld_cnt_q <= ld_cnt_d;
            br_cnt_q <= br_cnt_d;
        end
    end

endmodule
